pc_fetch_reg: RTL and testbench

// - Program-counter register feeding the ADD4 incrementer and instruction memory.
// - Selects next PC from ADD4 result, branch target or jump target; holds PC on stall or fetch backpressure.
// - Buffers a redirect that arrives while the fetch is not accepted; supports halt.
// - Counts accepted fetches.

---
 rtl/pc_fetch_reg.sv | 123 ++++++++++++
 tb/tb_pc_fetch_reg.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_reg.sv
// pc_fetch_reg: program-counter register for the fetch stage.
// Picks the next PC from add4_res, a branch target or a jump target.
// Holds PC on stall or IMEM backpressure, and buffers one redirect while no
// fetch is accepted. Supports halt and counts accepted fetches.
// Optional feature macro: PC_ALIGN_CHECK_EN. When it is defined, redirect
// targets are word-aligned and a sticky misalign flag is raised.
//
// Handshake: a fetch is accepted on a rising edge where fetch_valid=1,
// fetch_ready=1 and stall=0. fetch_valid does not depend on fetch_ready.
// pc_out stays stable while fetch_valid=1 and no accept happens.
module pc_fetch_reg #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      add4_res,
    output logic [31:0]      pc_out,
    output logic             fetch_valid,
    input  logic             fetch_ready,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    input  logic             jump,
    input  logic [31:0]      jump_target,
    input  logic             halt,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_count,
    output logic             misalign,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t      state;
    logic        pend_valid;
    logic [31:0] pend_target;
    logic        misalign_q;

    logic        accept;
    logic        live_redir;
    logic [31:0] live_target;
    logic        redir_use;
    logic [31:0] redir_target;
    logic [31:0] load_target;
    logic        target_bad;

    // Select the redirect source: a live jump wins over a live branch, and any
    // live redirect wins over a buffered one.
    always_comb begin
        accept       = fetch_valid & fetch_ready & ~stall;
        live_redir   = jump | branch_taken;
        live_target  = jump ? jump_target : branch_target;
        redir_use    = accept & (live_redir | pend_valid);
        redir_target = live_redir ? live_target : pend_target;
`ifdef PC_ALIGN_CHECK_EN
        load_target  = redir_target & ~32'h3;
        target_bad   = |redir_target[1:0];
`else
        load_target  = redir_target;
        target_bad   = 1'b0;
`endif
    end

    // FSM, PC register, pending redirect, fetch counter and sticky flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_BOOT;
            pc_out      <= RESET_VECTOR;
            fetch_valid <= 1'b0;
            halted      <= 1'b0;
            fetch_count <= '0;
            pend_valid  <= 1'b0;
            pend_target <= 32'h0;
            misalign_q  <= 1'b0;
        end else begin
            case (state)
                ST_BOOT: begin
                    state       <= ST_RUN;
                    fetch_valid <= 1'b1;
                end
                ST_RUN: begin
                    if (accept) begin
                        pc_out      <= redir_use ? load_target : add4_res;
                        fetch_count <= fetch_count + {{(CNT_W-1){1'b0}}, 1'b1};
                        // Any accept consumes or supersedes the buffered redirect.
                        pend_valid  <= 1'b0;
                        if (redir_use && target_bad) begin
                            misalign_q <= 1'b1;
                        end
                    end else if (live_redir) begin
                        pend_valid  <= 1'b1;
                        pend_target <= live_target;
                    end
                    // The fetch in flight this cycle still completes; halting
                    // only stops further requests.
                    if (halt) begin
                        state       <= ST_HALT;
                        fetch_valid <= 1'b0;
                        halted      <= 1'b1;
                    end
                end
                ST_HALT: begin
                    fetch_valid <= 1'b0;
                    halted      <= 1'b1;
                end
                default: begin
                    state       <= ST_HALT;
                    fetch_valid <= 1'b0;
                    halted      <= 1'b1;
                end
            endcase
        end
    end

    assign misalign  = misalign_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_pc_fetch_reg.sv
// Directed bench for pc_fetch_reg. It uses two instances: one with the default
// reset vector, and one that starts near the top of the address space to
// exercise PC wrap-around.
module tb_pc_fetch_reg;

    logic        clk;
    int          checks;
    int          errors;
    logic [31:0] exp_q[$];

    // DUT0 signals (default reset vector)
    logic        rst_n, fetch_ready, stall, branch_taken, jump, halt;
    logic [31:0] branch_target, jump_target, add4_res, pc_out;
    logic        fetch_valid, halted, misalign;
    logic [31:0] fetch_count;
    logic [1:0]  dbg_state;

    // DUT1 signals (reset vector near wrap)
    logic        rst1_n, ready1, halt1;
    logic [31:0] add4_1, pc1;
    logic        fv1, halted1, misalign1;
    logic [31:0] count1;
    logic [1:0]  dbg1;

    logic [31:0] mbase;
    logic        mexp;

    assign add4_res = pc_out + 32'd4;
    assign add4_1   = pc1 + 32'd4;

    pc_fetch_reg dut0 (
        .clk(clk), .rst_n(rst_n), .add4_res(add4_res), .pc_out(pc_out),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .halt(halt), .halted(halted),
        .fetch_count(fetch_count), .misalign(misalign), .dbg_state(dbg_state)
    );

    pc_fetch_reg #(.RESET_VECTOR(32'hFFFF_FFF8)) dut1 (
        .clk(clk), .rst_n(rst1_n), .add4_res(add4_1), .pc_out(pc1),
        .fetch_valid(fv1), .fetch_ready(ready1), .stall(1'b0),
        .branch_taken(1'b0), .branch_target(32'h0),
        .jump(1'b0), .jump_target(32'h0), .halt(halt1), .halted(halted1),
        .fetch_count(count1), .misalign(misalign1), .dbg_state(dbg1)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Driver helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: expected PCs are queued when the stimulus is driven.
    task automatic push_pc(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s observed=%h expected=<empty queue>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, e);
            end
        end
    endtask

    // Clock one cycle on DUT0 and check its PC and fetch count.
    task automatic step0(input string tag, input logic [31:0] pc_exp, input logic [31:0] cnt_exp);
        push_pc(pc_exp);
        tick();
        pop_chk(tag, pc_out);
        chk({tag, "_cnt"}, fetch_count, cnt_exp);
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; fetch_ready = 1'b1; stall = 1'b0; branch_taken = 1'b0;
        jump = 1'b0; halt = 1'b0; branch_target = 32'h0; jump_target = 32'h0;
        rst1_n = 1'b0; ready1 = 1'b1; halt1 = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_fv", {31'd0, fetch_valid}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_cnt", fetch_count, 32'd0);
        chk("rst_mis", {31'd0, misalign}, 32'd0);

        rst_n = 1'b1;
        chk("boot_state", {30'd0, dbg_state}, 32'd0);
        step0("boot_to_run", 32'h0, 32'd0);
        chk("run_fv", {31'd0, fetch_valid}, 32'd1);
        step0("inc4", 32'h4, 32'd1);
        step0("inc8", 32'h8, 32'd2);

        // Stall for three cycles at pc=8
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step0("stall_hold", 32'h8, 32'd2);
            chk("stall_fv", {31'd0, fetch_valid}, 32'd1);
        end
        stall = 1'b0;
        step0("stall_release", 32'hC, 32'd3);

        // Branch during backpressure is buffered until the next accept
        fetch_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h40;
        step0("bp_hold1", 32'hC, 32'd3);
        branch_taken = 1'b0; branch_target = 32'h0;
        step0("bp_hold2", 32'hC, 32'd3);
        fetch_ready = 1'b1;
        step0("pend_branch", 32'h40, 32'd4);
        step0("after_pend", 32'h44, 32'd5);

        // Jump beats branch on a live accept
        jump = 1'b1; jump_target = 32'h100; branch_taken = 1'b1; branch_target = 32'h200;
        step0("jump_prio", 32'h100, 32'd6);

        // Jump beats branch when buffered; a newer redirect overwrites the pending one
        stall = 1'b1; jump_target = 32'h300; branch_target = 32'h400;
        step0("pend_store", 32'h100, 32'd6);
        jump = 1'b0; branch_target = 32'h500;
        step0("pend_overwrite", 32'h100, 32'd6);
        stall = 1'b0; branch_taken = 1'b0;
        step0("pend_newest", 32'h500, 32'd7);
        step0("pend_cleared", 32'h504, 32'd8);

        // A live redirect beats the pending one and the pending one is dropped
        stall = 1'b1; jump = 1'b1; jump_target = 32'h600;
        step0("pend_store2", 32'h504, 32'd8);
        stall = 1'b0; jump = 1'b0; branch_taken = 1'b1; branch_target = 32'h700;
        step0("live_over_pend", 32'h700, 32'd9);
        branch_taken = 1'b0;
        step0("pend_dropped", 32'h704, 32'd10);

        // Misaligned jump target
`ifdef PC_ALIGN_CHECK_EN
        mbase = 32'h50; mexp = 1'b1;
`else
        mbase = 32'h52; mexp = 1'b0;
`endif
        jump = 1'b1; jump_target = 32'h52;
        step0("mis_jump", mbase, 32'd11);
        chk("mis_flag", {31'd0, misalign}, {31'd0, mexp});
        jump = 1'b0;
        step0("mis_inc1", mbase + 32'd4, 32'd12);
        step0("mis_inc2", mbase + 32'd8, 32'd13);
        chk("mis_sticky", {31'd0, misalign}, {31'd0, mexp});

        // Halt: the current fetch completes, then PC and count freeze
        halt = 1'b1;
        step0("halt_last", mbase + 32'd12, 32'd14);
        chk("halt_halted", {31'd0, halted}, 32'd1);
        chk("halt_fv", {31'd0, fetch_valid}, 32'd0);
        halt = 1'b0; jump = 1'b1; jump_target = 32'h900;
        step0("halt_frozen1", mbase + 32'd12, 32'd14);
        step0("halt_frozen2", mbase + 32'd12, 32'd14);
        chk("halt_stays", {31'd0, halted}, 32'd1);
        jump = 1'b0;

        // Asynchronous reset mid-operation, then halt held through BOOT
        rst_n = 1'b0;
        #1;
        chk("rst2_pc", pc_out, 32'h0);
        chk("rst2_cnt", fetch_count, 32'd0);
        chk("rst2_halted", {31'd0, halted}, 32'd0);
        chk("rst2_mis", {31'd0, misalign}, 32'd0);
        tick();
        rst_n = 1'b1; halt = 1'b1;
        step0("boot_halt_ignored", 32'h0, 32'd0);
        chk("boot_halt_run", {30'd0, dbg_state}, 32'd1);
        chk("boot_halt_halted", {31'd0, halted}, 32'd0);
        step0("run_halt", 32'h4, 32'd1);
        chk("run_halt_halted", {31'd0, halted}, 32'd1);
        halt = 1'b0;

        // Wrap-around from a high reset vector
        rst1_n = 1'b1;
        chk("w_reset_pc", pc1, 32'hFFFF_FFF8);
        push_pc(32'hFFFF_FFF8); tick(); pop_chk("w_pc0", pc1);
        push_pc(32'hFFFF_FFFC); tick(); pop_chk("w_pc1", pc1);
        push_pc(32'h0000_0000); tick(); pop_chk("w_pc2", pc1);
        chk("w_no_mis", {31'd0, misalign1}, 32'd0);
        push_pc(32'h0000_0004); tick(); pop_chk("w_pc3", pc1);
        halt1 = 1'b1;
        push_pc(32'h0000_0008); tick(); pop_chk("w_halt_pc", pc1);
        chk("w_halted", {31'd0, halted1}, 32'd1);
        chk("w_fv", {31'd0, fv1}, 32'd0);
        halt1 = 1'b0;
        push_pc(32'h0000_0008); tick(); pop_chk("w_frozen", pc1);
        chk("w_cnt", count1, 32'd4);

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL sb_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
